video_pattern_gen: RTL

//  Parametrised multi-mode test-pattern source for the HDMI/LCD display path.

---
 rtl/video_pattern_pkg.sv | 50 +++++
 rtl/video_pattern_gen_if.sv | 30 +++
 rtl/video_box_mover.sv | 94 +++++++++
 rtl/video_pattern_gen.sv | 107 ++++++++++
 4 files changed

// File: rtl/video_pattern_pkg.sv
// Shared types, palette and mode encodings
// for the video test-pattern generator.
package video_pattern_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_x_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_y_e;

  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t MAGENTA = 24'hFF00FF;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t BLACK   = 24'h000000;

  function automatic rgb_t bar_color(
    input logic [2:0] idx
  );
    rgb_t c;
    unique case (idx)
      3'd0: c = WHITE;
      3'd1: c = YELLOW;
      3'd2: c = CYAN;
      3'd3: c = GREEN;
      3'd4: c = MAGENTA;
      3'd5: c = RED;
      3'd6: c = BLUE;
      3'd7: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Pixel-position / pattern-output bundle
// between timing driver and pattern source.
interface video_pattern_gen_if;

  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [1:0]  mode_req;
  logic [23:0] pixel_data;
  logic [1:0]  mode_cur;
  logic [15:0] frame_cnt;

  modport master (
    output pixel_xpos,
    output pixel_ypos,
    output mode_req,
    input  pixel_data,
    input  mode_cur,
    input  frame_cnt
  );

  modport slave (
    input  pixel_xpos,
    input  pixel_ypos,
    input  mode_req,
    output pixel_data,
    output mode_cur,
    output frame_cnt
  );

endinterface

// File: rtl/video_box_mover.sv
// Two-axis bounce FSM for the bouncing box,
// stepping once per start of frame.
module video_box_mover
  import video_pattern_pkg::*;
#(
  parameter int H_DISP   = 1280,
  parameter int V_DISP   = 720,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  localparam logic [11:0] X_MAX = 12'(H_DISP - BOX_SIZE);
  localparam logic [11:0] Y_MAX = 12'(V_DISP - BOX_SIZE);
  localparam logic [11:0] STEP  = 12'(BOX_STEP);
  localparam logic [10:0] STEP11 = 11'(BOX_STEP);

  dir_x_e      dx_q, dx_nxt;
  dir_y_e      dy_q, dy_nxt;
  logic [10:0] x_q, x_nxt;
  logic [10:0] y_q, y_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q <= DIR_RIGHT;
      dy_q <= DIR_DOWN;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      dx_q <= dx_nxt;
      dy_q <= dy_nxt;
      x_q  <= x_nxt;
      y_q  <= y_nxt;
    end
  end

  // The edge-touch position is emitted before the reversal takes effect.
  always_comb begin
    dx_nxt = dx_q;
    x_nxt  = x_q;
    if (sof) begin
      unique case (dx_q)
        DIR_RIGHT:
          if (({1'b0, x_q} + STEP) >= X_MAX) begin
            x_nxt  = X_MAX[10:0];
            dx_nxt = DIR_LEFT;
          end else begin
            x_nxt = x_q + STEP11;
          end
        DIR_LEFT:
          if ({1'b0, x_q} <= STEP) begin
            x_nxt  = '0;
            dx_nxt = DIR_RIGHT;
          end else begin
            x_nxt = x_q - STEP11;
          end
      endcase
    end
  end

  always_comb begin
    dy_nxt = dy_q;
    y_nxt  = y_q;
    if (sof) begin
      unique case (dy_q)
        DIR_DOWN:
          if (({1'b0, y_q} + STEP) >= Y_MAX) begin
            y_nxt  = Y_MAX[10:0];
            dy_nxt = DIR_UP;
          end else begin
            y_nxt = y_q + STEP11;
          end
        DIR_UP:
          if ({1'b0, y_q} <= STEP) begin
            y_nxt  = '0;
            dy_nxt = DIR_DOWN;
          end else begin
            y_nxt = y_q - STEP11;
          end
      endcase
    end
  end

  always_comb begin
    box_x = x_q;
    box_y = y_q;
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode test-pattern source: bars, checker,
// gradient and bouncing box, registered RGB888 out.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int BAR_NUM    = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 4
) (
  input logic                pixel_clk,
  input logic                rst_n,
  video_pattern_gen_if.slave bus
);

  localparam int BAR_W = H_DISP / BAR_NUM;
  localparam logic [11:0] H_LIM = 12'(H_DISP);
  localparam logic [11:0] V_LIM = 12'(V_DISP);
  localparam logic [11:0] BOX_W = 12'(BOX_SIZE);

  logic        at_origin, at_origin_q, sof;
  mode_e       mode_q, mode_eff;
  logic [15:0] frame_q;
  logic [7:0]  grad_b;
  rgb_t        pix_q, pix_d;
  logic [2:0]  bar_idx;
  logic [10:0] box_x, box_y;
  logic [11:0] xe, ye, bxe, bye;
  logic        active, in_box;

  assign at_origin = (bus.pixel_xpos == '0)
                   && (bus.pixel_ypos == '0);
  assign sof = at_origin & ~at_origin_q;

  video_box_mover #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_box (
    .clk  (pixel_clk),
    .rst_n(rst_n),
    .sof  (sof),
    .box_x(box_x),
    .box_y(box_y)
  );

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      at_origin_q <= 1'b0;
      mode_q      <= MODE_BARS;
      frame_q     <= '0;
      pix_q       <= BLACK;
    end else begin
      at_origin_q <= at_origin;
      pix_q       <= pix_d;
      if (sof) begin
        mode_q  <= mode_e'(bus.mode_req);
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  // The SOF pixel already belongs to the new frame.
  assign mode_eff = sof ? mode_e'(bus.mode_req) : mode_q;
  assign grad_b   = sof ? frame_q[7:0] + 8'd1 : frame_q[7:0];

  assign xe  = {1'b0, bus.pixel_xpos};
  assign ye  = {1'b0, bus.pixel_ypos};
  assign bxe = {1'b0, box_x};
  assign bye = {1'b0, box_y};

  assign active = (xe < H_LIM) && (ye < V_LIM);
  assign in_box = (xe >= bxe) && (xe < bxe + BOX_W)
               && (ye >= bye) && (ye < bye + BOX_W);

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < BAR_NUM; i++) begin
      if (xe >= 12'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    pix_d = BLACK;
    unique case (mode_eff)
      MODE_BARS:
        pix_d = bar_color(bar_idx);
      MODE_CHECK:
        pix_d = (bus.pixel_xpos[CHECK_LOG2]
               ^ bus.pixel_ypos[CHECK_LOG2]) ? BLACK : WHITE;
      MODE_GRAD:
        pix_d = {bus.pixel_xpos[7:0],
                 bus.pixel_ypos[7:0], grad_b};
      MODE_BOX:
        pix_d = in_box ? WHITE : BLUE;
    endcase
    if (!active) pix_d = BLACK;
  end

  assign bus.pixel_data = pix_q;
  assign bus.mode_cur   = mode_q;
  assign bus.frame_cnt  = frame_q;

endmodule
